// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - opcodes, FSM state encoding and INSTR field positions for regfile_seq_ctrl
package regfile_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int DST_HI  = 5;
  localparam int DST_LO  = 4;
  localparam int SRC1_HI = 3;
  localparam int SRC1_LO = 2;
  localparam int SRC2_HI = 1;
  localparam int SRC2_LO = 0;

endpackage

// File: rtl/regfile_alu.sv
// rtl/regfile_alu.sv - combinational ALU for regfile_seq_ctrl; FLAGS_EN adds carry/borrow output
module regfile_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result
`ifdef FLAGS_EN
  ,
  output logic              o_carry
`endif
);

`ifdef FLAGS_EN
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  // Extended subtraction: the top bit is the borrow, set exactly when a < b.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      OP_AND:  o_result = i_a & i_b;
      default: o_result = i_imm;
    endcase
  end
`else
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      default: o_result = i_imm;
    endcase
  end
`endif

endmodule

// File: rtl/regfile_seq_ctrl.sv
// rtl/regfile_seq_ctrl.sv - 4-state initiator that reads, computes and writes back one instruction
// to the register file per handshake; FLAGS_EN adds registered ZERO/CARRY outputs.
module regfile_seq_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [7:0]        INSTR,
  input  logic [DATA_W-1:0] IMM,
  output logic [ADDR_W-1:0] R1,
  output logic [ADDR_W-1:0] R2,
  input  logic [DATA_W-1:0] RD1,
  input  logic [DATA_W-1:0] RD2,
  output logic [ADDR_W-1:0] W,
  output logic [DATA_W-1:0] WD,
  output logic              RW,
  output logic              DONE
`ifdef FLAGS_EN
  ,
  output logic              ZERO,
  output logic              CARRY
`endif
);

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_r1;
  logic [ADDR_W-1:0] r_r2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [DATA_W-1:0] r_result;
  logic [ADDR_W-1:0] r_w;
  logic [DATA_W-1:0] w_alu_result;

`ifdef FLAGS_EN
  logic w_alu_carry;
  logic r_carry;
  logic r_zero_flag;
  logic r_carry_flag;
`endif

  regfile_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op    (r_op),
    .i_a     (r_op_a),
    .i_b     (r_op_b),
    .i_imm   (r_imm),
    .o_result(w_alu_result)
`ifdef FLAGS_EN
    ,
    .o_carry (w_alu_carry)
`endif
  );

  // Strobes decode straight from state so the async reset drops RW immediately.
  assign IN_READY = (r_state == ST_IDLE);
  assign RW       = (r_state == ST_WRITE);
  assign DONE     = (r_state == ST_WRITE);
  assign R1       = r_r1;
  assign R2       = r_r2;
  assign W        = r_w;
  assign WD       = r_result;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_dst    <= '0;
      r_r1     <= '0;
      r_r2     <= '0;
      r_imm    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_w      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_op    <= INSTR[OP_HI:OP_LO];
            r_dst   <= ADDR_W'(INSTR[DST_HI:DST_LO]);
            r_r1    <= ADDR_W'(INSTR[SRC1_HI:SRC1_LO]);
            r_r2    <= ADDR_W'(INSTR[SRC2_HI:SRC2_LO]);
            r_imm   <= IMM;
            r_state <= ST_READ;
          end
        end
        ST_READ: begin
          r_op_a  <= RD1;
          r_op_b  <= RD2;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result <= w_alu_result;
          r_w      <= r_dst;
          r_state  <= ST_WRITE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FLAGS_EN
  assign ZERO  = r_zero_flag;
  assign CARRY = r_carry_flag;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_carry      <= 1'b0;
      r_zero_flag  <= 1'b0;
      r_carry_flag <= 1'b0;
    end else begin
      if (r_state == ST_EXEC) begin
        r_carry <= w_alu_carry;
      end
      if (r_state == ST_WRITE) begin
        r_zero_flag  <= (r_result == '0);
        r_carry_flag <= r_carry;
      end
    end
  end
`endif

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb/tb_regfile_seq_ctrl.sv - scoreboard bench for regfile_seq_ctrl driving a 4x8 register file
module tb_regfile_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] INSTR;
  logic [7:0] IMM;
  logic [1:0] R1, R2, W;
  logic [7:0] RD1, RD2, WD;
  logic       RW, DONE;
`ifdef FLAGS_EN
  logic       ZERO, CARRY;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       zero;
    logic       carry;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m[4];
  logic [7:0] rf[4];

  always #5 CLK = ~CLK;

  regfile_seq_ctrl dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .INSTR   (INSTR),
    .IMM     (IMM),
    .R1      (R1),
    .R2      (R2),
    .RD1     (RD1),
    .RD2     (RD2),
    .W       (W),
    .WD      (WD),
    .RW      (RW),
    .DONE    (DONE)
`ifdef FLAGS_EN
    ,
    .ZERO    (ZERO),
    .CARRY   (CARRY)
`endif
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (RW) begin
      rf[W] <= WD;
    end
  end

  assign RD1 = rf[R1];
  assign RD2 = rf[R2];

  task automatic predict(input logic [7:0] instr, input logic [7:0] imm);
    exp_t       e;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] r;
    a = m[instr[3:2]];
    b = m[instr[1:0]];
    case (instr[7:6])
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {(a < b), 8'(a - b)};
      2'b10:   r = {1'b0, a & b};
      default: r = {1'b0, imm};
    endcase
    e.addr  = instr[5:4];
    e.data  = r[7:0];
    e.carry = r[8];
    e.zero  = (r[7:0] == 8'h00);
    m[instr[5:4]] = r[7:0];
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (IN_READY !== 1'b1 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout got %b want 1", name, IN_READY);
    end
  endtask

  // Starts at the negedge after the accept edge; write must appear on the lat-th negedge.
  task automatic expect_write(input string name, input int lat);
    exp_t e;
    for (int k = 1; k < lat; k++) begin
      @(negedge CLK);
      checks++;
      if (RW !== 1'b0 || IN_READY !== 1'b0) begin
        errors++;
        $display("FAIL %s_early cycle %0d RW=%b IN_READY=%b want 0/0", name, k, RW, IN_READY);
      end
    end
    @(negedge CLK);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty got 0 entries want 1", name);
      return;
    end
    e = sb.pop_front();
    if (RW !== 1'b1 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL %s_strobe RW=%b DONE=%b want 1/1", name, RW, DONE);
    end
    checks++;
    if (W !== e.addr) begin
      errors++;
      $display("FAIL %s_W got %0d want %0d", name, W, e.addr);
    end
    checks++;
    if (WD !== e.data) begin
      errors++;
      $display("FAIL %s_WD got %h want %h", name, WD, e.data);
    end
    @(negedge CLK);
    checks++;
    if (RW !== 1'b0 || DONE !== 1'b0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s_after RW=%b DONE=%b IN_READY=%b want 0/0/1", name, RW, DONE, IN_READY);
    end
`ifdef FLAGS_EN
    checks++;
    if (ZERO !== e.zero || CARRY !== e.carry) begin
      errors++;
      $display("FAIL %s_flags ZERO=%b CARRY=%b want %b/%b", name, ZERO, CARRY, e.zero, e.carry);
    end
`endif
  endtask

  task automatic run_instr(input logic [7:0] instr, input logic [7:0] imm, input string name);
    wait_ready(name);
    IN_VALID = 1'b1;
    INSTR    = instr;
    IMM      = imm;
    predict(instr, imm);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    expect_write(name, 3);
  endtask

  task automatic check_idle_reset(input string name);
    checks++;
    if (IN_READY !== 1'b1 || RW !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl IN_READY=%b RW=%b DONE=%b want 1/0/0", name, IN_READY, RW, DONE);
    end
    checks++;
    if (R1 !== 2'd0 || R2 !== 2'd0 || W !== 2'd0 || WD !== 8'h00) begin
      errors++;
      $display("FAIL %s_regs R1=%0d R2=%0d W=%0d WD=%h want 0/0/0/00", name, R1, R2, W, WD);
    end
`ifdef FLAGS_EN
    checks++;
    if (ZERO !== 1'b0 || CARRY !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags ZERO=%b CARRY=%b want 0/0", name, ZERO, CARRY);
    end
`endif
  endtask

  task automatic test_reset();
    RESET    = 1'b1;
    IN_VALID = 1'b0;
    INSTR    = 8'h00;
    IMM      = 8'h00;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    #12;
    check_idle_reset("reset_hold");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check_idle_reset("reset_release");
  endtask

  task automatic test_ops();
    run_instr(8'hD0, 8'h2A, "ldi_r1_2a");
    run_instr(8'hE0, 8'h05, "ldi_r2_05");
    run_instr(8'h36, 8'h00, "add_r3_2f");
    run_instr(8'hD0, 8'h05, "ldi_r1_05");
    run_instr(8'hE0, 8'h2A, "ldi_r2_2a");
    run_instr(8'h46, 8'h00, "sub_r0_db");
    run_instr(8'hC0, 8'hFF, "ldi_r0_ff");
    run_instr(8'hD0, 8'h01, "ldi_r1_01");
    run_instr(8'h01, 8'h00, "add_wrap_00");
    run_instr(8'hA6, 8'h00, "and_r2");
    run_instr(8'h55, 8'h00, "sub_self_dst");
  endtask

  task automatic test_back_to_back();
    wait_ready("b2b");
    IN_VALID = 1'b1;
    INSTR    = 8'hE0;
    IMM      = 8'h10;
    predict(8'hE0, 8'h10);
    @(posedge CLK);
    #1;
    INSTR = 8'h3A;
    IMM   = 8'h00;
    predict(8'h3A, 8'h00);
    expect_write("b2b_first", 3);
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    expect_write("b2b_second", 3);
  endtask

  task automatic test_random();
    logic [7:0] instr;
    logic [7:0] imm;
    for (int i = 0; i < 12; i++) begin
      instr = 8'($urandom);
      imm   = 8'($urandom);
      run_instr(instr, imm, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_reset_mid_op();
    int rw_seen;
    wait_ready("rst_mid");
    IN_VALID = 1'b1;
    INSTR    = 8'hDE;
    IMM      = 8'h77;
    @(posedge CLK);
    #1 IN_VALID = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 RESET = 1'b1;
    #1;
    check_idle_reset("rst_mid");
    #1 RESET = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    rw_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (RW !== 1'b0) rw_seen++;
    end
    checks++;
    if (rw_seen != 0) begin
      errors++;
      $display("FAIL rst_mid_no_write got %0d RW pulses want 0", rw_seen);
    end
    run_instr(8'h15, 8'h00, "rst_mid_r1_zero");
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
